// File: rtl/counter_seq.sv
// Sequencer for an external 8-bit counter: clear, optional preset load, then
// prescaled count-enable pulses until the counter reaches a captured target.
module counter_seq #(
    parameter logic [25:0] TICK_DIV = 26'd5000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic       use_load,
    input  logic [7:0] preset,
    input  logic [7:0] target,
    input  logic [7:0] q_in,
    output logic       ncclr,
    output logic       ncload,
    output logic       nccken,
    output logic [7:0] load_data,
    output logic       busy,
    output logic       done,
    output logic       tick_led
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] presc_q, presc_d;
    logic [7:0]  preset_q, preset_d;
    logic [7:0]  target_q, target_d;
    logic        use_load_q, use_load_d;
    logic        ncclr_q, ncclr_d;
    logic        ncload_q, ncload_d;
    logic        nccken_q, nccken_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick_led_q, tick_led_d;
    logic        tick;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        preset_d   = preset_q;
        target_d   = target_q;
        use_load_d = use_load_q;
        tick       = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (start && !abort) begin
                    preset_d   = preset;
                    target_d   = target;
                    use_load_d = use_load;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                presc_d = '0;
                state_d = use_load_q ? LOAD : RUN;
            end
            LOAD: begin
                presc_d = '0;
                state_d = RUN;
            end
            RUN: begin
                // Reaching the target wins over a coincident tick, so the counter never overshoots.
                if (q_in == target_q) begin
                    presc_d = '0;
                    state_d = DONE;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (presc_q == TICK_DIV - 26'd1) begin
                    tick    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 26'd1;
                end
            end
            PAUSE: begin
                if (!pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                presc_d = '0;
                state_d = IDLE;
            end
            default: begin
                presc_d = '0;
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            presc_d = '0;
            tick    = 1'b0;
        end

        // Outputs are registered from the next state so they line up with the state they describe.
        ncclr_d    = (state_d != CLEAR);
        ncload_d   = (state_d != LOAD);
        nccken_d   = !tick;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        tick_led_d = tick_led_q ^ tick;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            preset_q   <= '0;
            target_q   <= '0;
            use_load_q <= 1'b0;
            ncclr_q    <= 1'b1;
            ncload_q   <= 1'b1;
            nccken_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_led_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            preset_q   <= preset_d;
            target_q   <= target_d;
            use_load_q <= use_load_d;
            ncclr_q    <= ncclr_d;
            ncload_q   <= ncload_d;
            nccken_q   <= nccken_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tick_led_q <= tick_led_d;
        end
    end

    assign ncclr     = ncclr_q;
    assign ncload    = ncload_q;
    assign nccken    = nccken_q;
    assign load_data = preset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tick_led  = tick_led_q;

endmodule

// File: tb/tb_counter_seq.sv
// Self-checking bench for counter_seq: models the external counter and predicts
// every output cycle from the sequence arithmetic (distance, tick period, pauses).
module tb_counter_seq;

    localparam logic [25:0] TD  = 26'd4;
    localparam int          TDI = 4;

    logic       clk = 1'b0;
    logic       clr, start, abort, pause, use_load;
    logic [7:0] preset, target, q_in;
    logic       ncclr, ncload, nccken, busy, done, tick_led;
    logic [7:0] load_data;
    logic [7:0] q_model = 8'd0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       ul;
        logic [7:0] pre;
        logic [7:0] tgt;
        bit         noisy;
        int         enables;
        logic [7:0] final_q;
    } vec_t;

    always #5 clk = ~clk;

    counter_seq #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .abort    (abort),
        .pause    (pause),
        .use_load (use_load),
        .preset   (preset),
        .target   (target),
        .q_in     (q_in),
        .ncclr    (ncclr),
        .ncload   (ncload),
        .nccken   (nccken),
        .load_data(load_data),
        .busy     (busy),
        .done     (done),
        .tick_led (tick_led)
    );

    // External counter: clear/load/enable act on the next rising edge
    always @(posedge clk) begin
        if (!ncclr)       q_model <= 8'd0;
        else if (!ncload) q_model <= load_data;
        else if (!nccken) q_model <= q_model + 8'd1;
    end
    assign q_in = q_model;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] outVec();
        return {26'd0, ncclr, ncload, nccken, busy, done, tick_led};
    endfunction

    // One full sequence without pause; expected outputs derived from the distance to the target
    task automatic applyStimulus(input logic ul, input logic [7:0] pre, input logic [7:0] tgt,
                                 input bit noisy, input string tag, output int enables_seen);
        int   base, n, c0, done_r, r, k_sofar, last_t;
        logic led0, exp_cken;
        logic [5:0] exp;
        led0   = tick_led;
        base   = ul ? int'(pre) : 0;
        n      = (int'(tgt) - base) & 255;
        c0     = ul ? 3 : 2;
        done_r = (n == 0) ? 1 : n * TDI + 2;
        last_t = c0 + done_r + 1;
        use_load = ul; preset = pre; target = tgt; start = 1'b1;
        stepCycle();
        start = 1'b0;
        enables_seen = 0;
        for (int t = 1; t <= last_t; t++) begin
            r        = t - c0;
            k_sofar  = (r > 0) ? ((r / TDI < n) ? r / TDI : n) : 0;
            exp_cken = !(r >= TDI && (r % TDI) == 0 && (r / TDI) <= n);
            exp      = {t != 1, !(ul && t == 2), exp_cken, t < last_t, r == done_r, led0 ^ k_sofar[0]};
            if (!nccken) enables_seen++;
            checkOutput($sformatf("%s_t%0d", tag, t), outVec(), {26'd0, exp});
            if (noisy && t < last_t) begin
                start    = 1'($urandom_range(1, 0));
                preset   = 8'($urandom);
                target   = 8'($urandom);
                use_load = 1'($urandom_range(1, 0));
            end else begin
                start = 1'b0;
            end
            stepCycle();
        end
        start = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        int   en;
        int   r;
        logic led0;
        logic [7:0] pre_r, tgt_r;
        logic ul_r;
        logic [5:0] exp;
        int   k;

        clr = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; use_load = 1'b0;
        preset = 8'h00; target = 8'h00;
        stepCycle();
        stepCycle();
        checkOutput("reset_outputs", outVec(), {26'd0, 6'b111000});
        checkOutput("reset_load_data", {24'd0, load_data}, 32'd0);
        clr = 1'b0;
        stepCycle();

        vecs[0] = '{ul: 1'b1, pre: 8'd5,   tgt: 8'd8, noisy: 1'b0, enables: 3, final_q: 8'd8};
        vecs[1] = '{ul: 1'b0, pre: 8'd77,  tgt: 8'd0, noisy: 1'b1, enables: 0, final_q: 8'd0};
        vecs[2] = '{ul: 1'b1, pre: 8'd254, tgt: 8'd1, noisy: 1'b1, enables: 3, final_q: 8'd1};
        vecs[3] = '{ul: 1'b1, pre: 8'd7,   tgt: 8'd7, noisy: 1'b1, enables: 0, final_q: 8'd7};
        vecs[4] = '{ul: 1'b0, pre: 8'd200, tgt: 8'd3, noisy: 1'b1, enables: 3, final_q: 8'd3};

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].ul, vecs[i].pre, vecs[i].tgt, vecs[i].noisy, $sformatf("vec%0d", i), en);
            checkOutput($sformatf("vec%0d_enables", i), 32'(en), 32'(vecs[i].enables));
            checkOutput($sformatf("vec%0d_final_q", i), {24'd0, q_model}, {24'd0, vecs[i].final_q});
        end

        for (int i = 0; i < 8; i++) begin
            ul_r  = 1'($urandom_range(1, 0));
            pre_r = 8'($urandom);
            tgt_r = (ul_r ? pre_r : 8'd0) + 8'($urandom_range(40, 0));
            applyStimulus(ul_r, pre_r, tgt_r, 1'b1, $sformatf("rnd%0d", i), en);
            checkOutput($sformatf("rnd%0d_enables", i), 32'(en), 32'((int'(tgt_r) - (ul_r ? int'(pre_r) : 0)) & 255));
            checkOutput($sformatf("rnd%0d_final_q", i), {24'd0, q_model}, {24'd0, tgt_r});
        end

        // Abort beats start while idle
        start = 1'b1; abort = 1'b1;
        stepCycle();
        start = 1'b0; abort = 1'b0;
        checkOutput("abort_over_start", outVec() & 32'h3C, {26'd0, 6'b111000} & 32'h3C);

        // Abort while loading
        use_load = 1'b1; preset = 8'd10; target = 8'd20; start = 1'b1;
        stepCycle();
        start = 1'b0;
        stepCycle();
        checkOutput("abort_in_load_state", {31'd0, ncload}, 32'd0);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abort_in_load_next", outVec() & 32'h3C, {26'd0, 6'b111000} & 32'h3C);
        for (int t = 0; t < 5; t++) begin
            stepCycle();
            checkOutput($sformatf("abort_quiet_%0d", t), {30'd0, busy, done}, 32'd0);
        end

        // Pause for ten cycles after the first enable: enables at RUN cycles 4, 19, 23
        led0 = tick_led;
        use_load = 1'b1; preset = 8'd5; target = 8'd8; start = 1'b1;
        stepCycle();
        start = 1'b0;
        en = 0;
        for (int t = 1; t <= 29; t++) begin
            r = t - 3;
            k = (r >= 23) ? 3 : (r >= 19) ? 2 : (r >= 4) ? 1 : 0;
            exp = {t != 1, t != 2, !(r == 4 || r == 19 || r == 23), r <= 25, r == 25, led0 ^ k[0]};
            if (!nccken) en++;
            checkOutput($sformatf("pause_t%0d", t), outVec(), {26'd0, exp});
            pause = (r >= 5 && r <= 14);
            stepCycle();
        end
        pause = 1'b0;
        checkOutput("pause_enables", 32'(en), 32'd3);
        checkOutput("pause_final_q", {24'd0, q_model}, 32'd8);

        // Clear in the middle of RUN
        led0 = tick_led;
        use_load = 1'b0; preset = 8'hA5; target = 8'd50; start = 1'b1;
        stepCycle();
        start = 1'b0;
        for (int t = 1; t < 6; t++) stepCycle();
        checkOutput("clr_run_enable", {30'd0, nccken, tick_led}, {30'd0, 1'b0, !led0});
        clr = 1'b1;
        stepCycle();
        clr = 1'b0;
        checkOutput("clr_run_outputs", outVec(), {26'd0, 6'b111000});
        checkOutput("clr_run_load_data", {24'd0, load_data}, 32'd0);
        for (int t = 0; t < 5; t++) begin
            stepCycle();
            checkOutput($sformatf("clr_quiet_%0d", t), {30'd0, busy, done}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
